rat_int_ctrl: RTL and testbench

Interrupt controller for the RAT MCU. It collects eight external interrupt requests and applies a software-programmable mask and a fixed priority. It drives the MCU's single `INT` input and sequences each request through assert, acknowledge and end-of-service. The MCU programs and inspects the controller through the I/O port space (`PORT_ID`, `OUT_PORT`, `IO_STRB`), and the controller returns read data on the `IN_PORT` mux.

---
 rtl/rat_io_pkg.sv | 20 ++
 rtl/rat_int_ctrl_if.sv | 16 +
 rtl/prio_enc8.sv | 25 ++
 rtl/rat_int_ctrl.sv | 118 +++++++++++
 tb/tb_rat_int_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/rat_io_pkg.sv
// Shared I/O definitions for RAT MCU peripherals.
//   - Port offsets of the interrupt controller register block
//   - Interrupt controller FSM state encoding
//   - Bit position of the in-service flag in the ACTIVE register
package rat_io_pkg;

  localparam logic [1:0] INTC_MASK   = 2'd0;
  localparam logic [1:0] INTC_PEND   = 2'd1;
  localparam logic [1:0] INTC_ACTIVE = 2'd2;
  localparam logic [1:0] INTC_EOI    = 2'd3;

  localparam int ACTIVE_INSVC_BIT = 7;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    SERVICE
  } intc_state_t;

endpackage

// File: rtl/rat_int_ctrl_if.sv
// MCU I/O port bus as seen by a peripheral.
//   PORT_ID  : port address           (MCU -> peripheral)
//   OUT_PORT : write data             (MCU -> peripheral)
//   IO_STRB  : one-cycle write strobe (MCU -> peripheral)
//   RD_DATA  : read data for IN_PORT  (peripheral -> MCU)
//   RD_HIT   : PORT_ID addresses this peripheral (peripheral -> MCU)
interface rat_int_ctrl_if;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] RD_DATA;
  logic       RD_HIT;

  modport master (output PORT_ID, OUT_PORT, IO_STRB, input  RD_DATA, RD_HIT);
  modport slave  (input  PORT_ID, OUT_PORT, IO_STRB, output RD_DATA, RD_HIT);
endinterface

// File: rtl/prio_enc8.sv
// Fixed-priority encoder, lowest set index wins.
//   req   : 8 request bits
//   idx   : index of the lowest set bit (0 when none set)
//   valid : at least one request bit set
module prio_enc8 (
  input  logic [7:0] req,
  output logic [2:0] idx,
  output logic       valid
);

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned; otherwise a latch is inferred.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Scan downward so the last (lowest) set bit overwrites higher ones.
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) begin
        idx   = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rat_int_ctrl.sv
// RAT MCU interrupt controller.
// Captures rising edges on eight IRQ lines into PEND, masks them with MASK,
// picks the lowest pending index and sequences it through
// IDLE -> ASSERT (INT high) -> SERVICE (after INT_ACK) -> IDLE (on EOI).
//   CLK, RESET : clock, synchronous active-high reset
//   IRQ        : level request lines, a rising edge is one request
//   INT_ACK    : control unit accepted the interrupt this cycle
//   INT        : interrupt request to the MCU (registered)
//   bus        : I/O port bus; registers at BASE_ID+0..3 (MASK, PEND, ACTIVE, EOI)
module rat_int_ctrl
  import rat_io_pkg::*;
#(
  parameter logic [7:0] BASE_ID = 8'hE0
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [7:0]         IRQ,
  input  logic               INT_ACK,
  output logic               INT,
  rat_int_ctrl_if.slave      bus
);

  intc_state_t state, state_next;
  logic [7:0]  mask, pend, pend_next, active, irq_q, irq_rise, req;
  logic [2:0]  win_idx;
  logic        win_valid, ack_take, int_q;

  // Address decode in 9 bits so a PORT_ID below BASE_ID wraps to a large
  // value instead of aliasing into the window.
  logic [8:0]  rel;
  logic [1:0]  off;
  logic        hit, wr_en;

  assign rel   = {1'b0, bus.PORT_ID} - {1'b0, BASE_ID};
  assign hit   = (rel < 9'd4);
  assign off   = rel[1:0];
  assign wr_en = bus.IO_STRB & hit;

  assign irq_rise = IRQ & ~irq_q;
  assign req      = pend & mask;

  prio_enc8 u_prio (
    .req   (req),
    .idx   (win_idx),
    .valid (win_valid)
  );

  // Next state; the winner is taken in the ACK cycle so a higher-priority
  // arrival during ASSERT is the one serviced.
  always_comb begin
    state_next = state;
    ack_take   = 1'b0;
    unique case (state)
      IDLE:    if (win_valid) state_next = ASSERT;
      ASSERT: begin
        if (!win_valid) begin
          state_next = IDLE;
        end else if (INT_ACK) begin
          state_next = SERVICE;
          ack_take   = 1'b1;
        end
      end
      SERVICE: if (wr_en && off == INTC_EOI) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // New edges are OR-ed in last so a set always beats a same-cycle clear.
  always_comb begin
    pend_next = pend;
    if (wr_en && off == INTC_PEND) pend_next = pend_next & ~bus.OUT_PORT;
    if (ack_take) pend_next[win_idx] = 1'b0;
    pend_next = pend_next | irq_rise;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      int_q  <= 1'b0;
      mask   <= '0;
      pend   <= '0;
      active <= '0;
      irq_q  <= '0;
    end else begin
      irq_q <= IRQ;
      state <= state_next;
      int_q <= (state_next == ASSERT);
      pend  <= pend_next;
      if (wr_en && off == INTC_MASK) mask <= bus.OUT_PORT;
      if (ack_take) begin
        active <= {1'b1, 4'b0000, win_idx};
      end else if (state == SERVICE && state_next == IDLE) begin
        active[ACTIVE_INSVC_BIT] <= 1'b0;  // index bits stay for inspection
      end
    end
  end

  assign INT = int_q;

  logic [7:0] rd_data;
  always_comb begin
    rd_data = '0;
    if (hit) begin
      unique case (off)
        INTC_MASK:   rd_data = mask;
        INTC_PEND:   rd_data = pend;
        INTC_ACTIVE: rd_data = active;
        default:     rd_data = '0;  // EOI is write-only
      endcase
    end
  end

  assign bus.RD_DATA = rd_data;
  assign bus.RD_HIT  = hit;

endmodule

// File: tb/tb_rat_int_ctrl.sv
// Scoreboard bench for rat_int_ctrl: stimulus pushes expected values for the
// current cycle, a monitor pops and compares them on the falling edge.
module tb_rat_int_ctrl;
  import rat_io_pkg::*;

  localparam logic [7:0] BASE = 8'hE0;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] IRQ;
  logic       INT_ACK;
  logic       INT;

  rat_int_ctrl_if bus ();

  rat_int_ctrl #(.BASE_ID(BASE)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .IRQ     (IRQ),
    .INT_ACK (INT_ACK),
    .INT     (INT),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  typedef enum {K_RD, K_HIT, K_INT} kind_t;
  typedef struct {
    string      name;
    kind_t      kind;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  // Monitor: everything queued during a cycle is checked at its falling edge.
  always @(negedge CLK) begin
    while (sb.size() > 0) begin
      exp_t       e;
      logic [7:0] act;
      e = sb.pop_front();
      case (e.kind)
        K_RD:    act = bus.RD_DATA;
        K_HIT:   act = {7'b0, bus.RD_HIT};
        default: act = {7'b0, INT};
      endcase
      check(e.name, act, e.exp);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    bus.IO_STRB = 1'b0;
    INT_ACK     = 1'b0;
  endtask

  task automatic wr(input logic [1:0] o, input logic [7:0] d);
    bus.PORT_ID  = BASE + 8'(o);
    bus.OUT_PORT = d;
    bus.IO_STRB  = 1'b1;
    tick();
  endtask

  task automatic rd(input logic [1:0] o, input logic [7:0] e, input string n);
    bus.PORT_ID = BASE + 8'(o);
    sb.push_back('{name: n, kind: K_RD, exp: e});
  endtask

  task automatic exp_int(input logic v, input string n);
    sb.push_back('{name: n, kind: K_INT, exp: {7'b0, v}});
  endtask

  task automatic exp_hit(input logic [7:0] port, input logic v, input string n);
    bus.PORT_ID = port;
    sb.push_back('{name: n, kind: K_HIT, exp: {7'b0, v}});
  endtask

  initial begin
    RESET = 1'b1; IRQ = '0; INT_ACK = 1'b0;
    bus.PORT_ID = '0; bus.OUT_PORT = '0; bus.IO_STRB = 1'b0;
    tick(); tick();
    RESET = 1'b0;

    // Reset state
    rd(INTC_MASK, 8'h00, "rst_mask"); exp_int(1'b0, "rst_int");
    #1; check("rst_mask_direct", bus.RD_DATA, 8'h00);
    check("rst_int_direct", {7'b0, INT}, 8'h00);
    tick();
    rd(INTC_PEND, 8'h00, "rst_pend"); tick();
    rd(INTC_ACTIVE, 8'h00, "rst_active"); tick();
    rd(INTC_EOI, 8'h00, "rst_eoi"); tick();
    exp_hit(8'h10, 1'b0, "hit_10");
    #1; check("hit_10_direct", {7'b0, bus.RD_HIT}, 8'h00);
    tick();
    bus.PORT_ID = 8'h10; sb.push_back('{name: "rd_10", kind: K_RD, exp: 8'h00});
    #1; check("rd_10_direct", bus.RD_DATA, 8'h00);
    tick();
    exp_hit(BASE + 8'd3, 1'b1, "hit_base3");
    #1; check("hit_base3_direct", {7'b0, bus.RD_HIT}, 8'h01);
    tick();

    // Single source 2
    wr(INTC_MASK, 8'h04);
    rd(INTC_MASK, 8'h04, "mask_04"); IRQ = 8'h04; tick();
    IRQ = 8'h00; rd(INTC_PEND, 8'h04, "pend_04"); exp_int(1'b0, "int_lat1"); tick();
    rd(INTC_PEND, 8'h04, "pend_04b"); exp_int(1'b1, "int_lat2");
    check("int_lat2_direct", {7'b0, INT}, 8'h01);
    INT_ACK = 1'b1; tick();
    rd(INTC_ACTIVE, 8'h82, "active_82"); exp_int(1'b0, "int_after_ack"); tick();
    rd(INTC_PEND, 8'h00, "pend_cleared"); tick();
    wr(INTC_EOI, 8'h5A);
    rd(INTC_ACTIVE, 8'h02, "active_eoi_02"); exp_int(1'b0, "int_idle"); tick();

    // Priority between sources 5 and 1
    wr(INTC_MASK, 8'hFF);
    IRQ = 8'h22; tick();
    IRQ = 8'h00; tick();
    exp_int(1'b1, "prio_int"); INT_ACK = 1'b1; tick();
    rd(INTC_ACTIVE, 8'h81, "active_81"); exp_int(1'b0, "prio_int_low"); tick();
    rd(INTC_PEND, 8'h20, "pend_20"); exp_int(1'b0, "no_nesting"); tick();
    wr(INTC_EOI, 8'h00);
    rd(INTC_ACTIVE, 8'h01, "active_01"); exp_int(1'b0, "eoi_int_0"); tick();
    exp_int(1'b1, "eoi_reassert"); INT_ACK = 1'b1; tick();
    rd(INTC_ACTIVE, 8'h85, "active_85"); tick();
    rd(INTC_PEND, 8'h00, "pend_00_after5"); tick();
    wr(INTC_EOI, 8'h00);
    rd(INTC_ACTIVE, 8'h05, "active_05"); tick();

    // Masked capture, unmask, W1C before ack
    wr(INTC_MASK, 8'h00);
    IRQ = 8'h08; tick();
    IRQ = 8'h00; rd(INTC_PEND, 8'h08, "pend_08"); exp_int(1'b0, "masked_int0"); tick();
    exp_int(1'b0, "masked_int1"); tick();
    wr(INTC_MASK, 8'h08);
    exp_int(1'b0, "unmask_int0"); tick();
    exp_int(1'b1, "unmask_int1");
    wr(INTC_PEND, 8'h08);
    rd(INTC_PEND, 8'h00, "w1c_pend"); exp_int(1'b1, "w1c_int_hold"); tick();
    exp_int(1'b0, "w1c_int_drop"); tick();
    rd(INTC_ACTIVE, 8'h05, "w1c_active_unchanged"); tick();

    // Source 0 in service, re-request and set-beats-clear
    wr(INTC_MASK, 8'h01);
    IRQ = 8'h01; tick();
    IRQ = 8'h00; tick();
    INT_ACK = 1'b1; tick();
    rd(INTC_ACTIVE, 8'h80, "active_80"); IRQ = 8'h01; tick();
    IRQ = 8'h00; rd(INTC_PEND, 8'h01, "svc_pend_01"); exp_int(1'b0, "svc_int0"); tick();
    exp_int(1'b0, "svc_int1"); tick();
    IRQ = 8'h01; wr(INTC_PEND, 8'h01);
    IRQ = 8'h00; rd(INTC_PEND, 8'h01, "set_beats_w1c"); exp_int(1'b0, "svc_int2"); tick();

    // Reset during ASSERT
    wr(INTC_EOI, 8'h00);
    tick();
    exp_int(1'b1, "pre_reset_int"); RESET = 1'b1; tick();
    RESET = 1'b0; INT_ACK = 1'b1;
    rd(INTC_MASK, 8'h00, "rr_mask"); exp_int(1'b0, "rr_int"); tick();
    rd(INTC_PEND, 8'h00, "rr_pend"); exp_int(1'b0, "rr_int_ack"); tick();
    rd(INTC_ACTIVE, 8'h00, "rr_active"); tick();

    // IRQ held high through reset counts as an edge
    IRQ = 8'h40; RESET = 1'b1; tick(); tick();
    RESET = 1'b0; tick();
    rd(INTC_PEND, 8'h40, "held_irq_edge"); exp_int(1'b0, "held_irq_int");
    #1; check("held_irq_edge_direct", bus.RD_DATA, 8'h40);
    tick();

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
